huff_feed_ctrl: RTL and testbench

- Sequencer in front of the Huffman bit buffer/decoder.
- Accepts packed, MSB-first bitstream words over a valid/ready stream and slices them into chunks of at most 4 bits.
- Issues each chunk to the decoder's load interface only when the buffer can take it, tracking buffer occupancy from the decoder's consume reports.
- Drains the buffer at end of frame and signals frame completion.

---
 rtl/huff_feed_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_huff_feed_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/huff_feed_ctrl.sv
// Slices MSB-first stream words into <=CHUNK_W-bit loads for the Huffman bit buffer.
// Optional drain watchdog enabled by defining HUFF_FEED_TIMEOUT_EN.
module huff_feed_ctrl #(
   parameter int WORD_W  = 16,
   parameter int CHUNK_W = 4,
   parameter int BUF_CAP = 9,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [WORD_W-1:0]  s_word,
   input  logic [4:0]         s_nbits,
   input  logic               s_last,
   input  logic               s_valid,
   output logic               s_ready,
   output logic [CHUNK_W-1:0] dec_bits,
   output logic [2:0]         dec_len,
   output logic               dec_valid,
   input  logic               dec_ready,
   input  logic               cons_valid,
   input  logic [3:0]         cons_len,
   output logic [3:0]         occupancy,
   output logic               frame_done,
   output logic               err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FEED  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [2:0] CHUNK_L = 3'(CHUNK_W);
   localparam logic [4:0] WORD_L  = 5'(WORD_W);
   localparam logic [4:0] CAP_L   = 5'(BUF_CAP);

   logic [1:0]         state_reg, state_next;
   logic [WORD_W-1:0]  word_reg, word_next;
   logic [4:0]         rem_reg, rem_next;
   logic               last_reg, last_next;
   logic [CHUNK_W-1:0] bits_reg, bits_next;
   logic [2:0]         len_reg, len_next;
   logic               valid_reg, valid_next;
   logic [3:0]         occ_reg, occ_next;
   logic               err_reg, err_next;
   logic               ready_reg;

   logic [2:0]         offer_len;
   logic [CHUNK_W-1:0] top_bits;
   logic [CHUNK_W-1:0] offer_bits;
   logic               offer_fits;
   logic               xfer;
   logic               word_bad;
   logic [4:0]         occ_add;
   logic [4:0]         rem_after;
   logic               timeout_hit;

   // Earliest stream bit sits at the MSB of the word register; right-align the chunk.
   assign offer_len  = (rem_reg >= 5'(CHUNK_W)) ? CHUNK_L : rem_reg[2:0];
   assign top_bits   = word_reg[WORD_W-1 -: CHUNK_W];
   assign offer_bits = top_bits >> (CHUNK_L - offer_len);
   assign offer_fits = ({1'b0, occ_reg} + {2'b0, offer_len}) <= CAP_L;
   assign xfer       = valid_reg && dec_ready;
   assign word_bad   = (s_nbits == 5'd0) || (s_nbits > WORD_L);
   assign occ_add    = {1'b0, occ_reg} + (xfer ? {2'b0, len_reg} : 5'd0);
   assign rem_after  = rem_reg - {2'b0, len_reg};

`ifdef HUFF_FEED_TIMEOUT_EN
   logic [3:0] wd_reg, wd_next;

   assign timeout_hit = (state_reg == ST_DRAIN) && !cons_valid && (wd_reg == 4'(TIMEOUT - 1));

   always_comb begin
      wd_next = 4'd0;
      if (state_reg == ST_DRAIN && !cons_valid) begin
         wd_next = wd_reg + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_reg <= 4'd0;
      end else begin
         wd_reg <= wd_next;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      word_next  = word_reg;
      rem_next   = rem_reg;
      last_next  = last_reg;
      bits_next  = bits_reg;
      len_next   = len_reg;
      valid_next = valid_reg;
      err_next   = err_reg;

      // Available bits include a chunk landing in the same cycle as the consume.
      occ_next = occ_add[3:0];
      if (cons_valid) begin
         if ({1'b0, cons_len} > occ_add) begin
            occ_next = 4'd0;
            err_next = 1'b1;
         end else begin
            occ_next = 4'(occ_add - {1'b0, cons_len});
         end
         if (state_reg == ST_IDLE && occ_reg == 4'd0) begin
            err_next = 1'b1;
         end
      end

      case (state_reg)
         ST_IDLE: begin
            if (s_valid && ready_reg) begin
               if (word_bad) begin
                  err_next = 1'b1;
                  if (s_last) begin
                     state_next = ST_DRAIN;
                  end
               end else begin
                  word_next  = s_word;
                  rem_next   = s_nbits;
                  last_next  = s_last;
                  state_next = ST_FEED;
               end
            end
         end
         ST_FEED: begin
            if (xfer) begin
               valid_next = 1'b0;
               word_next  = word_reg << len_reg;
               rem_next   = rem_after;
               if (rem_after == 5'd0) begin
                  state_next = last_reg ? ST_DRAIN : ST_IDLE;
               end
            end else if (!valid_reg && offer_fits) begin
               valid_next = 1'b1;
               bits_next  = offer_bits;
               len_next   = offer_len;
            end
         end
         ST_DRAIN: begin
            if (occ_reg == 4'd0) begin
               state_next = ST_DONE;
            end else if (timeout_hit) begin
               // Residual bits are frame padding the decoder will never ask for.
               err_next   = 1'b1;
               occ_next   = 4'd0;
               state_next = ST_DONE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         word_reg  <= '0;
         rem_reg   <= 5'd0;
         last_reg  <= 1'b0;
         bits_reg  <= '0;
         len_reg   <= 3'd0;
         valid_reg <= 1'b0;
         occ_reg   <= 4'd0;
         err_reg   <= 1'b0;
         ready_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         word_reg  <= word_next;
         rem_reg   <= rem_next;
         last_reg  <= last_next;
         bits_reg  <= bits_next;
         len_reg   <= len_next;
         valid_reg <= valid_next;
         occ_reg   <= occ_next;
         err_reg   <= err_next;
         ready_reg <= (state_next == ST_IDLE);
      end
   end

   assign s_ready    = ready_reg;
   assign dec_bits   = bits_reg;
   assign dec_len    = len_reg;
   assign dec_valid  = valid_reg;
   assign occupancy  = occ_reg;
   assign frame_done = (state_reg == ST_DONE);
   assign err        = err_reg;

endmodule

// File: tb/tb_huff_feed_ctrl.sv
// Scoreboarded bench for huff_feed_ctrl: expected chunks queued by stimulus, checked by a monitor.
module tb_huff_feed_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] s_word = '0;
   logic [4:0]  s_nbits = '0;
   logic        s_last = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [3:0]  dec_bits;
   logic [2:0]  dec_len;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic        cons_valid = 1'b0;
   logic [3:0]  cons_len = '0;
   logic [3:0]  occupancy;
   logic        frame_done;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;
   int max_occ = 0;
   logic [6:0] sb[$];

   bit         auto_cons = 1'b0;
   logic [1:0] xf_pipe = '0;
   logic [2:0] len_pipe0 = '0, len_pipe1 = '0;

   huff_feed_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .s_word(s_word), .s_nbits(s_nbits), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
      .dec_bits(dec_bits), .dec_len(dec_len), .dec_valid(dec_valid), .dec_ready(dec_ready),
      .cons_valid(cons_valid), .cons_len(cons_len),
      .occupancy(occupancy), .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("ok   %s: %0h", nm, act);
      end
   endtask

   // Monitor: every load transfer pops one expected chunk.
   initial begin
      forever begin
         @(negedge clk);
         if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
         if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL chunk_unexpected: got bits=%h len=%0d expected none", dec_bits, dec_len);
            end else begin
               logic [6:0] e;
               e = sb.pop_front();
               if ({dec_bits, dec_len} !== e) begin
                  n_bad++;
                  $display("FAIL chunk: got bits=%h len=%0d expected bits=%h len=%0d",
                           dec_bits, dec_len, e[6:3], e[2:0]);
               end else begin
                  $display("ok   chunk: bits=%h len=%0d", dec_bits, dec_len);
               end
            end
         end
      end
   end

   // One clock; models a decoder consuming each chunk two cycles after its load when enabled.
   task automatic tick();
      logic       xf;
      logic [2:0] ln;
      xf = dec_valid && dec_ready;
      ln = dec_len;
      @(posedge clk);
      #1;
      xf_pipe   = {xf_pipe[0], xf};
      len_pipe1 = len_pipe0;
      len_pipe0 = ln;
      if (auto_cons) begin
         cons_valid = xf_pipe[1];
         cons_len   = {1'b0, len_pipe1};
      end else begin
         cons_valid = 1'b0;
         cons_len   = 4'd0;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_word(input logic [15:0] w, input logic [4:0] nb, input logic lst);
      int waited = 0;
      while (s_ready !== 1'b1 && waited < 100) begin
         tick();
         waited++;
      end
      if (s_ready !== 1'b1) check("s_ready_wait", {31'd0, s_ready}, 32'd1);
      s_word  = w;
      s_nbits = nb;
      s_last  = lst;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic consume(input logic [3:0] n);
      cons_valid = 1'b1;
      cons_len   = n;
      tick();
   endtask

   task automatic wait_done(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         tick();
         if (frame_done === 1'b1) seen = 1'b1;
      end
      check(nm, {31'd0, seen}, 32'd1);
      tick();
      check({nm, "_one_cycle"}, {31'd0, frame_done}, 32'd0);
   endtask

   initial begin
      // Reset state
      ticks(2);
      check("rst_s_ready", {31'd0, s_ready}, 32'd0);
      check("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
      check("rst_occupancy", {28'd0, occupancy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      reset_n = 1'b1;
      tick();

      // Full word, streaming decoder
      dec_ready = 1'b1;
      auto_cons = 1'b1;
      sb.push_back({4'hA, 3'd4});
      sb.push_back({4'h5, 3'd4});
      sb.push_back({4'hC, 3'd4});
      sb.push_back({4'h3, 3'd4});
      send_word(16'hA5C3, 5'd16, 1'b1);
      wait_done("t1_frame_done");
      check("t1_occupancy", {28'd0, occupancy}, 32'd0);
      check("t1_err", {31'd0, err}, 32'd0);
      check("t1_max_occ_le_cap", {31'd0, max_occ <= 9}, 32'd1);
      check("t1_sb_empty", sb.size(), 32'd0);

      // Six-bit word ends in a short chunk
      sb.push_back({4'hB, 3'd4});
      sb.push_back({4'h1, 3'd2});
      send_word(16'hB400, 5'd6, 1'b1);
      wait_done("t2_frame_done");
      check("t2_sb_empty", sb.size(), 32'd0);
      ticks(3);
      auto_cons = 1'b0;
      tick();

      // Back-pressure from buffer capacity
      sb.push_back({4'h1, 3'd4});
      sb.push_back({4'h2, 3'd4});
      sb.push_back({4'h3, 3'd4});
      sb.push_back({4'h4, 3'd4});
      send_word(16'h1234, 5'd16, 1'b0);
      ticks(10);
      check("t3_occ_two_chunks", {28'd0, occupancy}, 32'd8);
      check("t3_withheld", {31'd0, dec_valid}, 32'd0);
      check("t3_sb_two_left", sb.size(), 32'd2);
      consume(4'd3);
      check("t3_occ_after_cons", {28'd0, occupancy}, 32'd5);
      ticks(2);
      check("t3_occ_third", {28'd0, occupancy}, 32'd9);
      ticks(3);
      check("t3_full_no_offer", {31'd0, dec_valid}, 32'd0);
      consume(4'd4);
      ticks(2);
      check("t3_occ_fourth", {28'd0, occupancy}, 32'd9);
      check("t3_s_ready_back", {31'd0, s_ready}, 32'd1);

      // Held offer, then same-cycle transfer and consume, then underflow
      dec_ready = 1'b0;
      consume(4'd4);
      check("t4_occ_5", {28'd0, occupancy}, 32'd5);
      sb.push_back({4'hE, 3'd4});
      send_word(16'hE000, 5'd4, 1'b1);
      tick();
      check("t4_offer_up", {31'd0, dec_valid}, 32'd1);
      ticks(5);
      check("t4_hold_valid", {31'd0, dec_valid}, 32'd1);
      check("t4_hold_bits", {28'd0, dec_bits}, 32'hE);
      check("t4_hold_len", {29'd0, dec_len}, 32'd4);
      check("t4_hold_occ", {28'd0, occupancy}, 32'd5);
      dec_ready = 1'b1;
      consume(4'd2);
      check("t4_occ_xfer_cons", {28'd0, occupancy}, 32'd7);
      consume(4'd4);
      check("t4_occ_3", {28'd0, occupancy}, 32'd3);
      check("t4_err_clear", {31'd0, err}, 32'd0);
      consume(4'd9);
      check("t4_underflow_occ", {28'd0, occupancy}, 32'd0);
      check("t4_underflow_err", {31'd0, err}, 32'd1);
      wait_done("t4_frame_done");

      // Asynchronous reset mid-frame
      dec_ready = 1'b0;
      send_word(16'hA5C3, 5'd16, 1'b1);
      ticks(2);
      check("t5_offer_up", {31'd0, dec_valid}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("t5_rst_dec_valid", {31'd0, dec_valid}, 32'd0);
      check("t5_rst_dec_bits", {28'd0, dec_bits}, 32'd0);
      check("t5_rst_dec_len", {29'd0, dec_len}, 32'd0);
      check("t5_rst_err", {31'd0, err}, 32'd0);
      check("t5_rst_s_ready", {31'd0, s_ready}, 32'd0);
      check("t5_rst_occ", {28'd0, occupancy}, 32'd0);
      tick();
      reset_n = 1'b1;
      dec_ready = 1'b1;
      ticks(4);
      check("t5_no_replay", {31'd0, dec_valid}, 32'd0);
      check("t5_idle_ready", {31'd0, s_ready}, 32'd1);

`ifdef HUFF_FEED_TIMEOUT_EN
      // Drain watchdog: two padding bits never consumed
      sb.push_back({4'h3, 3'd2});
      send_word(16'hC000, 5'd2, 1'b1);
      ticks(3);
      check("t6_occ_2", {28'd0, occupancy}, 32'd2);
      ticks(10);
      check("t6_not_yet", {31'd0, frame_done}, 32'd0);
      wait_done("t6_frame_done");
      check("t6_err", {31'd0, err}, 32'd1);
      check("t6_occ", {28'd0, occupancy}, 32'd0);
`endif

      ticks(2);
      check("final_sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
